// File: rtl/tqv_peri_pkg.sv
// rtl/tqv_peri_pkg.sv - shared TinyQV peripheral bus types, size codes and read-data masking
package tqv_peri_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Zero-extend responder data to the access size; an illegal size yields 0.
  function automatic logic [31:0] mask_rdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {24'h0, data[7:0]};
      SIZE_HALF: return {16'h0, data[15:0]};
      SIZE_WORD: return data;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/tqv_peri_initiator_if.sv
// rtl/tqv_peri_initiator_if.sv - request/response handshake and peripheral bus signals
interface tqv_peri_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, data_out, data_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, address, data_in, data_write_n, data_read_n
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, data_out, data_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, address, data_in, data_write_n, data_read_n
  );
endinterface

// File: rtl/tqv_peri_initiator.sv
// rtl/tqv_peri_initiator.sv - single-outstanding TinyQV peripheral bus initiator with read timeout
module tqv_peri_initiator
  import tqv_peri_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tqv_peri_initiator_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        address_q, address_d;
  logic [31:0]       data_in_q, data_in_d;
  logic [1:0]        write_n_q, write_n_d;
  logic [1:0]        read_n_q, read_n_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    write_n_d   = SIZE_NONE;
    read_n_d    = SIZE_NONE;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          size_d    = bus.req_size;
          address_d = bus.req_addr;
          data_in_d = bus.req_wdata;
          if (bus.req_size == SIZE_NONE) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d   = ST_WRITE;
            write_n_d = bus.req_size;
          end else begin
            state_d  = ST_READ;
            read_n_d = bus.req_size;
            cnt_d    = '0;
          end
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        // data_ready wins over the timeout when both land in the same cycle
        if (bus.data_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mask_rdata(size_q, bus.data_out);
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
        end else begin
          read_n_d = size_q;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= SIZE_NONE;
      cnt_q       <= '0;
      address_q   <= 6'h0;
      data_in_q   <= 32'h0;
      write_n_q   <= SIZE_NONE;
      read_n_q    <= SIZE_NONE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.address      = address_q;
  assign bus.data_in      = data_in_q;
  assign bus.data_write_n = write_n_q;
  assign bus.data_read_n  = read_n_q;

endmodule
